// File: rtl/mem_arbiter.sv
// mem_arbiter: CPU/aux arbiter onto one shared memory bus with timeout abort.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the CPU always wins.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic [DATA_W-1:0] aux_rdata,
  output logic              aux_ack,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy
);
  localparam int cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [cnt_w-1:0] tmax = cnt_w'(TIMEOUT);
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit rr = 1'b1;
`else
  localparam bit rr = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t           state, state_n;
  logic             owner, last_grant, pick_aux, expire, done, any_req;
  logic [cnt_w-1:0] cnt, cnt_inc;
  logic [DATA_W-1:0] rdata_n;
  always_comb begin
    any_req  = cpu_req | aux_req;
    pick_aux = (cpu_req & aux_req) ? (rr & ~last_grant) : aux_req;
    cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    expire   = (TIMEOUT != 0) && (cnt_inc == tmax);
    done     = mem_rdy | expire;
    rdata_n  = (mem_rdy & ~mem_we) ? mem_rdata : '0;
    state_n  = (state == IDLE)  ? (any_req ? ISSUE : IDLE) :
               (state == ISSUE) ? (done ? RESP : ISSUE) : IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      cpu_rdata  <= '0;
      aux_rdata  <= '0;
      cpu_ack    <= 1'b0;
      aux_ack    <= 1'b0;
      err        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state   <= state_n;
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;
      err     <= 1'b0;
      if (state == IDLE && any_req) begin
        owner     <= pick_aux;
        cnt       <= '0;
        mem_req   <= 1'b1;
        mem_we    <= pick_aux ? aux_we : cpu_we;
        mem_addr  <= pick_aux ? aux_addr : cpu_addr;
        mem_wdata <= pick_aux ? aux_wdata : cpu_wdata;
      end
      if (state == ISSUE) begin
        cnt <= cnt_inc;
        if (done) begin
          mem_req <= 1'b0;
          cpu_ack <= ~owner;
          aux_ack <= owner;
          err     <= ~mem_rdy;
          if (owner) aux_rdata <= rdata_n;
          else cpu_rdata <= rdata_n;
        end
      end
      if (state == RESP) last_grant <= owner;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table, hand corner sequences and randomized transactions
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  localparam int TO = 4;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0, aux_req = 0, aux_we = 0, mem_rdy = 0;
  logic [31:0] cpu_addr = 0, aux_addr = 0;
  logic [15:0] cpu_wdata = 0, aux_wdata = 0, mem_rdata = 0;
  logic [15:0] cpu_rdata, aux_rdata, mem_wdata;
  logic [31:0] mem_addr;
  logic cpu_ack, aux_ack, err, mem_req, mem_we;
  int n_cmp = 0, n_bad = 0;
  bit last_aux = 1;
  logic [15:0] m_cpu = 0, m_aux = 0;

  typedef struct {
    bit cr; bit cwe; logic [31:0] caddr; logic [15:0] cwd;
    bit ar; bit awe; logic [31:0] aaddr; logic [15:0] awd;
    int delay; logic [15:0] rd; bit drop;
    bit win; bit xerr; logic [15:0] xrdata;
  } vec_t;
  vec_t tbl[11];

  mem_arbiter #(.ADDR_W(32), .DATA_W(16), .TIMEOUT(TO)) dut (
    .CLK(clk), .RST(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_ack(aux_ack), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_cpu_rdata"}, cpu_rdata, 0);
    chk({nm, "_aux_rdata"}, aux_rdata, 0);
    chk({nm, "_acks_err"}, {cpu_ack, aux_ack, err}, 0);
    chk({nm, "_mem_req_we"}, {mem_req, mem_we}, 0);
    chk({nm, "_mem_addr"}, mem_addr, 0);
    chk({nm, "_mem_wdata"}, mem_wdata, 0);
  endtask

  function automatic bit pick(bit cr, bit ar);
    return (cr && ar) ? (RR ? !last_aux : 1'b0) : ar;
  endfunction

  function automatic vec_t mk(bit cr, bit cwe, logic [31:0] caddr, logic [15:0] cwd,
                              bit ar, bit awe, logic [31:0] aaddr, logic [15:0] awd,
                              int delay, logic [15:0] rd, bit drop,
                              bit win, bit xerr, logic [15:0] xrdata);
    vec_t v;
    v.cr = cr; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.ar = ar; v.awe = awe; v.aaddr = aaddr; v.awd = awd;
    v.delay = delay; v.rd = rd; v.drop = drop;
    v.win = win; v.xerr = xerr; v.xrdata = xrdata;
    return v;
  endfunction

  // One full access from an IDLE cycle back to the following IDLE cycle.
  task automatic txn(input vec_t v);
    cpu_req = v.cr; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    aux_req = v.ar; aux_we = v.awe; aux_addr = v.aaddr; aux_wdata = v.awd;
    step();
    chk("grant_addr", mem_addr, v.win ? v.aaddr : v.caddr);
    chk("mem_we", mem_we, v.win ? v.awe : v.cwe);
    chk("mem_wdata", mem_wdata, v.win ? v.awd : v.cwd);
    for (int k = 0; k < TO; k++) begin
      chk("mem_req_issue", mem_req, 1);
      chk("early_ack", {cpu_ack, aux_ack, err}, 0);
      if (k == v.delay) begin mem_rdy = 1; mem_rdata = v.rd; end
      if (k == 0 && v.drop) begin if (v.win) aux_req = 0; else cpu_req = 0; end
      step();
      mem_rdy = 0;
      mem_rdata = 16'($urandom);
      if (k == v.delay) break;
    end
    if (v.win) m_aux = v.xrdata; else m_cpu = v.xrdata;
    chk("resp_acks", {cpu_ack, aux_ack}, v.win ? 2'b01 : 2'b10);
    chk("resp_err", err, v.xerr);
    chk("resp_mem_req", mem_req, 0);
    chk("resp_cpu_rdata", cpu_rdata, m_cpu);
    chk("resp_aux_rdata", aux_rdata, m_aux);
    if (v.win) aux_req = 0; else cpu_req = 0;
    mem_rdy = 1;
    step();
    mem_rdy = 0;
    last_aux = v.win;
    chk("idle_acks_err", {cpu_ack, aux_ack, err, mem_req}, 0);
    chk("idle_rdata_hold", {cpu_rdata, aux_rdata}, {m_cpu, m_aux});
  endtask

  initial begin
    tbl[0] = mk(1, 0, 32'h0000_0010, 16'h0, 0, 0, 32'h0, 16'h0, 0, 16'hBEEF, 0, 0, 0, 16'hBEEF);
    tbl[1] = mk(0, 0, 32'h0, 16'h0, 1, 1, 32'h0001_0004, 16'h1234, 1, 16'h5555, 0, 1, 0, 16'h0);
    for (int i = 0; i < 6; i++)
      tbl[2 + i] = mk(1, 0, 32'h0000_2000, 16'h0, 1, 1, 32'h0000_3000, 16'hA000,
                      0, 16'h1100 + 16'(i), 0, RR ? bit'(i % 2) : 1'b0, 0,
                      (RR && (i % 2 == 1)) ? 16'h0 : 16'h1100 + 16'(i));
    tbl[8] = mk(1, 0, 32'h0000_0040, 16'h0, 0, 0, 32'h0, 16'h0, 99, 16'hFFFF, 0, 0, 1, 16'h0);
    tbl[9] = mk(1, 0, 32'h0000_0044, 16'h0, 0, 0, 32'h0, 16'h0, 2, 16'hA5A5, 0, 0, 0, 16'hA5A5);
    tbl[10] = mk(0, 0, 32'h0, 16'h0, 1, 0, 32'h0000_8000, 16'h0, 3, 16'h7E57, 1, 1, 0, 16'h7E57);

    rst = 1;
    repeat (3) step();
    chk_zero("reset");
    rst = 0;
    step();
    chk_zero("post_reset_idle");

    foreach (tbl[i]) txn(tbl[i]);

    // spurious mem_rdy while idle must not produce an ack
    cpu_req = 0; aux_req = 0; mem_rdy = 1; mem_rdata = 16'h4321;
    repeat (2) begin
      step();
      chk("idle_rdy_no_ack", {cpu_ack, aux_ack, err, mem_req}, 0);
    end
    mem_rdy = 0;
    chk("idle_rdy_rdata_hold", {cpu_rdata, aux_rdata}, {m_cpu, m_aux});

    // reset in the 2nd ISSUE cycle drops the access with no ack
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'hDEAD_0000; cpu_wdata = 16'hFFFF;
    step();
    chk("rst_seq_issue1", mem_req, 1);
    step();
    chk("rst_seq_issue2", mem_req, 1);
    rst = 1;
    step();
    chk_zero("mid_issue_reset");
    rst = 0; cpu_req = 0;
    m_cpu = 0; m_aux = 0; last_aux = 1;
    for (int k = 0; k < TO + 3; k++) begin
      step();
      chk("no_ack_after_reset", {cpu_ack, aux_ack, err, mem_req}, 0);
    end
    // after reset a tie goes to the CPU in either mode
    txn(mk(1, 0, 32'h0000_0080, 16'h0, 1, 0, 32'h0000_0090, 16'h0, 0, 16'h0C0C, 0, 0, 0, 16'h0C0C));

    for (int n = 0; n < 200; n++) begin
      vec_t v;
      bit cr, ar;
      cr = bit'($urandom % 2);
      ar = cr ? bit'($urandom % 2) : 1'b1;
      v = mk(cr, bit'($urandom % 2), $urandom, 16'($urandom),
             ar, bit'($urandom % 2), $urandom, 16'($urandom),
             int'($urandom_range(0, TO + 1)), 16'($urandom), bit'($urandom % 2), 0, 0, 0);
      v.win = pick(cr, ar);
      v.xerr = v.delay >= TO;
      v.xrdata = (v.xerr || (v.win ? v.awe : v.cwe)) ? 16'h0 : v.rd;
      txn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single 16-bit memory bus between the CPU's memory port and an auxiliary requester (DMA/IO/loader). It accepts one access at a time and drives the shared memory request/address/data lines. It returns read data with a one-cycle acknowledge to the granted requester and aborts accesses the memory never completes. It sits between the CPU core's memory port and the memory/peripheral fabric.

## Interface
- ADDR_W, 32, address width (matches CPU address bus)
- DATA_W, 16, data width
- TIMEOUT, 255, max cycles in ISSUE without mem_rdy before abort; 0 disables timeout
- Clocking: one clock; reset is synchronous and active-high.
- CLK  in  1  clock; all state changes on posedge
- RST  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU access address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  read data; valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- aux_req, aux_we, aux_addr, aux_wdata  in  1/1/ADDR_W/DATA_W  auxiliary port, same semantics as the CPU port
- aux_rdata, aux_ack  out  DATA_W/1  auxiliary port response, same semantics as the CPU port
- err  out  1  one-cycle pulse with the ack of a timed-out access
- mem_req  out  1  memory access strobe
- mem_we  out  1  memory write enable; valid while mem_req=1
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_rdy
- mem_rdy  in  1  memory completion pulse

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE
  - No request: stay in IDLE.
  - Any request: choose a winner, latch its we/addr/wdata into the mem_* registers, record `owner`, clear the timeout counter, go to ISSUE.
- ISSUE
  - mem_req=1.
  - If mem_rdy=1: latch mem_rdata into the owner's rdata register (writes latch 0), go to RESP.
  - Otherwise increment the counter. If TIMEOUT≠0 and the counter reaches TIMEOUT: set the abort flag, latch rdata=0, go to RESP.
- RESP
  - The owner's ack=1; err=abort flag.
  - mem_req=0.
  - Update last_grant=owner. Go to IDLE unconditionally.
  - Requests are not sampled in RESP.
- Non-owner ack/rdata stay 0. rdata registers reset to 0 and hold their last value otherwise.
- mem_rdy is ignored outside ISSUE.
- Requester inputs are not re-sampled after the grant. A requester dropping req during ISSUE still receives its ack.
- Counter width is clog2(TIMEOUT+1) bits and saturates; it never wraps.
- RST in any state: synchronous return to IDLE. All outputs go to 0, last_grant=AUX, abort flag cleared. An in-flight access is dropped with no ack.
- Reset values: every output is 0 (cpu_rdata, aux_rdata, cpu_ack, aux_ack, err, mem_req, mem_we, mem_addr, mem_wdata).

## Timing
- Request high before edge N in IDLE → mem_req high from cycle N+1.
- mem_rdy sampled high at edge M → ack/rdata high for exactly cycle M+1.
- Minimum latency from req to ack: 2 cycles, when mem_rdy is asserted in the first ISSUE cycle.
- Minimum access period: 3 cycles (IDLE→ISSUE→RESP).
- Timeout abort: ack+err after TIMEOUT ISSUE cycles, plus 1 cycle.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined
  - When both requesters are active in IDLE, grant the one ≠ last_grant.
  - last_grant resets to AUX, so the CPU wins the first tie.
- ARB_ROUND_ROBIN_EN undefined
  - Fixed priority: the CPU always wins ties; aux is granted only when cpu_req=0 in IDLE.
  - last_grant is still tracked but unused.

## Test plan
- Single CPU read, addr 0x0000_0010, mem_rdy one cycle after mem_req, mem_rdata 0xBEEF → mem_we=0, mem_addr=0x10, cpu_ack one cycle with cpu_rdata=0xBEEF, aux_ack=0.
- Aux write, addr 0x0001_0004, wdata 0x1234 → mem_req/mem_we=1, mem_addr=0x10004, mem_wdata=0x1234; aux_ack pulse and aux_rdata=0.
- Both requesters held high for 6 accesses, mem_rdy immediate:
  - with macro → grants CPU, AUX, CPU, AUX, CPU, AUX;
  - without macro → 6 CPU grants, aux starved.
- TIMEOUT=4, mem_rdy never asserted on a CPU read → mem_req high 4 cycles, then cpu_ack and err pulse together with cpu_rdata=0; next request serviced normally.
- RST asserted in the 2nd ISSUE cycle → next cycle all outputs 0, state IDLE, no ack ever issued for that access; subsequent CPU read completes normally.
- mem_rdy pulsed in IDLE and RESP, and aux_req dropped mid-ISSUE → spurious mem_rdy produces no ack; the aux access still completes with a single aux_ack.
